// File: rtl/gbuff_arbiter.sv
// Arbiter sharing one global-buffer port among NREQ requesters; reads return one cycle later.
// Define GBUFF_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module gbuff_arbiter #(
  parameter int NREQ = 3,
  parameter int WORD = 32,
  parameter int INDX = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_wr,
  input  logic [NREQ*INDX-1:0]   req_index,
  input  logic [NREQ*WORD-1:0]   req_wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rd_valid,
  output logic [WORD-1:0]        rd_data,
  output logic                   gb_wr_en,
  output logic [INDX-1:0]        gb_index,
  output logic [WORD-1:0]        gb_data_in,
  input  logic [WORD-1:0]        gb_data_out,
  output logic [15:0]            stall_cnt
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] REQ_ONE = NREQ'(1);

  logic [NREQ-1:0] gnt_raw;
  logic [PTRW-1:0] gidx;
  logic            gany;
  logic            grant_any;

  logic [NREQ-1:0] rd_valid_q, rd_valid_d;
  logic [WORD-1:0] rd_data_q, rd_data_d;
  logic [15:0]     stall_q, stall_d;
  logic            contended;

`ifdef GBUFF_ARB_FIXED_PRIO_EN

  always_comb begin
    gnt_raw = '0;
    gidx    = '0;
    gany    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gany && req[k]) begin
        gany       = 1'b1;
        gidx       = PTRW'(k);
        gnt_raw[k] = 1'b1;
      end
    end
  end

`else

  logic [PTRW-1:0] ptr_q, ptr_d;

  // Sum never exceeds 2*NREQ-2, so a single conditional subtract is a full modulo.
  function automatic logic [PTRW-1:0] wrap_add(input logic [PTRW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PTRW'(s);
  endfunction

  always_comb begin
    gnt_raw = '0;
    gidx    = '0;
    gany    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gany && req[wrap_add(ptr_q, k)]) begin
        gany                       = 1'b1;
        gidx                       = wrap_add(ptr_q, k);
        gnt_raw[wrap_add(ptr_q, k)] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) ptr_d = wrap_add(gidx, 1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

`endif

  assign grant_any = gany & ~rst;
  assign gnt       = rst ? '0 : gnt_raw;

  always_comb begin
    gb_wr_en   = 1'b0;
    gb_index   = '0;
    gb_data_in = '0;
    if (grant_any) begin
      gb_wr_en   = req_wr[gidx];
      gb_index   = req_index[gidx*INDX +: INDX];
      gb_data_in = req_wdata[gidx*WORD +: WORD];
    end
  end

  // The buffer registers its read output, so the grant cycle's read lands one cycle later.
  assign rd_valid_d = gnt & ~req_wr;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = (|rd_valid_q) ? gb_data_out : rd_data_q;
  assign rd_data_d  = (|rd_valid_q) ? gb_data_out : rd_data_q;

  assign contended = |(req & (req - REQ_ONE));
  assign stall_d   = (contended && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
  assign stall_cnt = stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      stall_q    <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      stall_q    <= stall_d;
    end
  end

endmodule

// File: tb/tb_gbuff_arbiter.sv
// Scoreboard bench for gbuff_arbiter: random held requests plus directed scenarios.
// Honours GBUFF_ARB_FIXED_PRIO_EN in its reference model.
module tb_gbuff_arbiter;
  localparam int NREQ = 3;
  localparam int WORD = 32;
  localparam int INDX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ-1:0]      req_wr = '0;
  logic [NREQ*INDX-1:0] req_index = '0;
  logic [NREQ*WORD-1:0] req_wdata = '0;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rd_valid;
  logic [WORD-1:0]      rd_data;
  logic                 gb_wr_en;
  logic [INDX-1:0]      gb_index;
  logic [WORD-1:0]      gb_data_in;
  logic [WORD-1:0]      gb_data_out = '0;
  logic [15:0]          stall_cnt;

  gbuff_arbiter #(.NREQ(NREQ), .WORD(WORD), .INDX(INDX)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_index(req_index),
    .req_wdata(req_wdata), .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .gb_wr_en(gb_wr_en), .gb_index(gb_index), .gb_data_in(gb_data_in),
    .gb_data_out(gb_data_out), .stall_cnt(stall_cnt)
  );

  // Global buffer with registered read port
  logic [WORD-1:0] buf_mem [0:(1<<INDX)-1] = '{default: '0};
  always @(posedge clk) begin
    if (gb_wr_en) buf_mem[gb_index] <= gb_data_in;
    gb_data_out <= buf_mem[gb_index];
  end

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic            wr_en;
    logic [INDX-1:0] idx;
    logic [WORD-1:0] wdata;
    logic [15:0]     stall;
    logic [NREQ-1:0] rdv;
    logic [WORD-1:0] hold;
  } cyc_t;
  typedef struct {
    logic [NREQ-1:0] who;
    logic [WORD-1:0] data;
  } rd_t;

  cyc_t cyc_q[$];
  rd_t  rd_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (values visible during the current cycle)
  int              m_ptr = 0;
  int              m_stall = 0;
  logic [NREQ-1:0] m_prev_rd = '0;
  logic [WORD-1:0] m_prev_data = '0;
  logic [WORD-1:0] m_hold = '0;
  logic [WORD-1:0] m_mem [0:(1<<INDX)-1] = '{default: '0};

  logic [NREQ-1:0] c_req = '0;
  logic [NREQ-1:0] c_wr = '0;
  logic [INDX-1:0] c_idx [NREQ] = '{default: '0};
  logic [WORD-1:0] c_data [NREQ] = '{default: '0};
  int              last_g = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] r);
    int start;
`ifdef GBUFF_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < NREQ; k++)
      if (r[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  task automatic drive_cycle(input logic r);
    int   g;
    cyc_t e;
    rd_t  rr;
    @(posedge clk); #1;
    rst    = r;
    req    = c_req;
    req_wr = c_wr;
    for (int i = 0; i < NREQ; i++) begin
      req_index[i*INDX +: INDX] = c_idx[i];
      req_wdata[i*WORD +: WORD] = c_data[i];
    end
    g = r ? -1 : model_pick(c_req);
    e.gnt   = (g >= 0) ? (NREQ'(1) << g) : '0;
    e.wr_en = (g >= 0) ? c_wr[g] : 1'b0;
    e.idx   = (g >= 0) ? c_idx[g] : '0;
    e.wdata = (g >= 0) ? c_data[g] : '0;
    e.stall = 16'(m_stall);
    e.rdv   = m_prev_rd;
    e.hold  = m_hold;
    cyc_q.push_back(e);
    if (g >= 0 && !c_wr[g]) begin
      rr.who  = NREQ'(1) << g;
      rr.data = m_mem[c_idx[g]];
      rd_q.push_back(rr);
    end
    if (r) begin
      m_hold = '0; m_ptr = 0; m_stall = 0; m_prev_rd = '0;
    end else begin
      if (m_prev_rd != '0) m_hold = m_prev_data;
      m_prev_rd = '0;
      if (g >= 0) begin
        m_ptr = (g + 1) % NREQ;
        if (c_wr[g]) m_mem[c_idx[g]] = c_data[g];
        else begin
          m_prev_rd   = NREQ'(1) << g;
          m_prev_data = m_mem[c_idx[g]];
        end
      end
      if ($countones(c_req) > 1 && m_stall < 65535) m_stall++;
    end
    last_g = g;
  endtask

  task automatic set_req(input int i, input logic rq, input logic w, input int idx,
                         input logic [WORD-1:0] d);
    c_req[i] = rq; c_wr[i] = w; c_idx[i] = INDX'(idx); c_data[i] = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 0, '0);
  endtask

  // Pending requesters keep request and payload; everyone else re-rolls.
  task automatic next_random();
    for (int i = 0; i < NREQ; i++) begin
      if (!(c_req[i] && i != last_g)) begin
        c_req[i]  = 1'($urandom_range(0, 1));
        c_wr[i]   = 1'($urandom_range(0, 1));
        c_idx[i]  = INDX'($urandom_range(0, 15));
        c_data[i] = $urandom;
      end
    end
  endtask

  // Monitor
  initial begin
    cyc_t e;
    rd_t  rr;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("gnt", 64'(gnt), 64'(e.gnt));
        chk("gb_wr_en", 64'(gb_wr_en), 64'(e.wr_en));
        chk("gb_index", 64'(gb_index), 64'(e.idx));
        chk("gb_data_in", 64'(gb_data_in), 64'(e.wdata));
        chk("stall_cnt", 64'(stall_cnt), 64'(e.stall));
        chk("rd_valid", 64'(rd_valid), 64'(e.rdv));
        if (rd_valid != '0) begin
          if (rd_q.size() == 0) begin
            chk("rd_unexpected", 64'(rd_valid), 64'(0));
          end else begin
            rr = rd_q.pop_front();
            chk("rd_who", 64'(rd_valid), 64'(rr.who));
            chk("rd_data", 64'(rd_data), 64'(rr.data));
          end
        end else begin
          chk("rd_data_hold", 64'(rd_data), 64'(e.hold));
        end
      end
    end
  end

  logic [NREQ-1:0] exp_seq [6];

  initial begin
`ifdef GBUFF_ARB_FIXED_PRIO_EN
    exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
    repeat (2) @(posedge clk);

    // Write then read same index from another requester
    clear_all(); set_req(0, 1'b1, 1'b1, 5, 32'hDEADBEEF); drive_cycle(1'b0);
    clear_all(); set_req(1, 1'b1, 1'b0, 5, '0);           drive_cycle(1'b0);
    clear_all();                                          drive_cycle(1'b0);

    // All three contend for six cycles from reset
    drive_cycle(1'b1);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 0, '0);
    for (int n = 0; n < 6; n++) begin
      drive_cycle(1'b0); #2;
      chk("gnt_seq", 64'(gnt), 64'(exp_seq[n]));
    end
    clear_all(); drive_cycle(1'b0); #2;
    chk("stall_six", 64'(stall_cnt), 64'(6));

    // Back-to-back reads after writes
    for (int n = 0; n < 3; n++) begin
      clear_all(); set_req(2, 1'b1, 1'b1, n, WORD'(10 + n)); drive_cycle(1'b0);
    end
    for (int n = 0; n < 3; n++) begin
      clear_all(); set_req(2, 1'b1, 1'b0, n, '0); drive_cycle(1'b0);
    end
    clear_all(); drive_cycle(1'b0);

    // Read granted, then reset the following cycle
    clear_all(); set_req(1, 1'b1, 1'b0, 5, '0); drive_cycle(1'b0);
    drive_cycle(1'b1);
    clear_all(); drive_cycle(1'b0); #2;
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 1, '0);
    drive_cycle(1'b0); #2;
    chk("rst_ptr_gnt", 64'(gnt), 64'(3'b001));

    // Randomized traffic with occasional resets
    clear_all(); last_g = -1;
    for (int n = 0; n < 3000; n++) begin
      next_random();
      drive_cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    // Saturate the stall counter
    drive_cycle(1'b1);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, 7, 32'h5A5A_0000);
    repeat (65540) drive_cycle(1'b0);
    clear_all(); drive_cycle(1'b0); #2;
    chk("stall_sat", 64'(stall_cnt), 64'(16'hFFFF));

    drive_cycle(1'b0);
    @(negedge clk); #1;
    chk("rd_drain", 64'(rd_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gbuff_arbiter.md
GBUFF_ARBITER -- requirements
Module: gbuff_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3: number of requesters sharing one global-buffer port.
REQ-002 SHALL have parameter WORD, default 32: data word width.
REQ-003 SHALL have parameter INDX, default 8: buffer index width.
REQ-004 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have port req  input  NREQ: per-requester access request.
REQ-007 SHALL have port req_wr  input  NREQ: per-requester write(1) / read(0).
REQ-008 SHALL have port req_index  input  NREQ*INDX: packed per-requester index, requester i at bits [i*INDX +: INDX].
REQ-009 SHALL have port req_wdata  input  NREQ*WORD: packed per-requester write data, same packing.
REQ-010 SHALL have port gnt  output  NREQ: one-hot grant, combinational, same cycle as req.
REQ-011 SHALL have port rd_valid  output  NREQ: registered, one-hot, read data valid for requester i.
REQ-012 SHALL have port rd_data  output  WORD: read data, qualified by rd_valid.
REQ-013 SHALL have port gb_wr_en  output  1: to buffer write enable.
REQ-014 SHALL have port gb_index  output  INDX: to buffer index.
REQ-015 SHALL have port gb_data_in  output  WORD: to buffer write data.
REQ-016 SHALL have port gb_data_out  input  WORD: from buffer registered read data.
REQ-017 SHALL have port stall_cnt  output  16: saturating count of cycles with at least one ungranted request.

Function
REQ-018 SHALL grant at most one requester per cycle; gnt is 0 when req is 0.
REQ-019 SHALL arbitrate round-robin: search begins at pointer ptr, wraps NREQ-1 -> 0; first asserted req wins.
REQ-020 SHALL update ptr to (granted index + 1) mod NREQ on each grant cycle; ptr holds otherwise.
REQ-021 SHALL drive gb_wr_en = req_wr[g], gb_index = req_index[g], gb_data_in = req_wdata[g] for granted g, same cycle.
REQ-022 SHALL drive gb_wr_en = 0, gb_index = 0, gb_data_in = 0 when no grant.
REQ-023 SHALL, for a granted read in cycle N, assert rd_valid[g] in cycle N+1 with rd_data = gb_data_out (1-cycle latency).
REQ-024 SHALL keep rd_valid all-zero after write grants and idle cycles; rd_data holds its last value.
REQ-025 SHALL allow back-to-back reads from the same or different requesters every cycle, each with 1-cycle latency.
REQ-026 SHALL treat requests as held: an ungranted requester keeps req and payload stable; arbiter never drops a pending request.
REQ-027 SHALL complete a write at the clock edge ending its grant cycle; a read granted the next cycle to the same index returns the new data.
REQ-028 SHALL increment stall_cnt when popcount(req) > 1 (any requester losing), saturating at 16'hFFFF.
REQ-029 SHALL guarantee any continuously asserted req is granted within NREQ cycles (round-robin mode).

Reset
REQ-030 SHALL, when rst is high at a clock edge, set ptr = 0, rd_valid = 0, rd_data = 0, stall_cnt = 0.
REQ-031 SHALL force gnt = 0 and gb_wr_en = 0 while rst is high; no buffer access is issued.
REQ-032 SHALL discard a read granted in the cycle before reset; no rd_valid after reset.

Configuration
REQ-033 SHALL, with GBUFF_ARB_FIXED_PRIO_EN defined, use fixed priority (lowest index wins), remove ptr, and keep REQ-028 counting unchanged.
REQ-034 SHALL, without GBUFF_ARB_FIXED_PRIO_EN, use round-robin per REQ-019/020.

Verification
REQ-035 SHALL cover: req0 write idx 5 data 32'hDEADBEEF, then req1 read idx 5 -> gnt=3'b010, next cycle rd_valid=3'b010, rd_data=32'hDEADBEEF.
REQ-036 SHALL cover: req=3'b111 held 6 cycles from reset -> gnt sequence 001,010,100,001,010,100; stall_cnt=6 (round-robin).
REQ-037 SHALL cover: same stimulus with GBUFF_ARB_FIXED_PRIO_EN -> gnt=001 every cycle; stall_cnt=6.
REQ-038 SHALL cover: req2 reads idx 0,1,2 on consecutive cycles after writes 10,11,12 -> rd_valid[2] three cycles, rd_data 10,11,12.
REQ-039 SHALL cover: read granted in cycle N, rst asserted in cycle N+1 -> rd_valid=0, rd_data=0, ptr=0 after edge.
REQ-040 SHALL cover: stall_cnt preloaded near max via 65536 contended cycles -> holds 16'hFFFF.
